// File: rtl/serial_wb_pkg.sv
// Shared definitions for the serial Wishbone bridge (initiator and remote master).
package serial_wb_pkg;

  // Bit positions inside the op byte of a command frame
  localparam int unsigned OP_WE_BIT      = 0;
  localparam int unsigned OP_AUTOINC_BIT = 1;

  // Width of the per-state byte counter
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSendOp,
    StSendAddr,
    StSendCount,
    StSendData,
    StRecvData,
    StAck
  } state_e;

  // Number of bytes used to carry an address of the given width
  function automatic int unsigned addr_bytes(input int unsigned addr_bits);
    return (addr_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/wb_serial_initiator.sv
// Wishbone (pipelined) slave that serialises each access into a single-beat command frame on
// an 8-bit stream and collects read data from the response stream. One transaction in flight.
module wb_serial_initiator
  import serial_wb_pkg::*;
#(
  parameter int unsigned BYTES     = 1,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned SEL_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 sresetn,
  input  logic [ADDR_BITS-1:0] s_wb_addr,
  input  logic [BYTES*8-1:0]   s_wb_dat_m2s,
  output logic [BYTES*8-1:0]   s_wb_dat_s2m,
  input  logic                 s_wb_we,
  input  logic [SEL_WIDTH-1:0] s_wb_sel,
  input  logic                 s_wb_stb,
  input  logic                 s_wb_cyc,
  output logic                 s_wb_ack,
  output logic                 s_wb_stall,
  input  logic                 axis_o_tready,
  output logic                 axis_o_tvalid,
  output logic                 axis_o_tlast,
  output logic [7:0]           axis_o_tdata,
  output logic                 axis_i_tready,
  input  logic                 axis_i_tvalid,
  input  logic                 axis_i_tlast,
  input  logic [7:0]           axis_i_tdata
);

  localparam int unsigned ADDRESS_BYTES = addr_bytes(ADDR_BITS);
  localparam int unsigned AW            = ADDRESS_BYTES * 8;
  localparam int unsigned DW            = BYTES * 8;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_BYTES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d, data_shl;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             we_q, we_d;
  logic             abort_q, abort_d;

  // Byte enables are not supported and tlast on responses carries no extra information
  logic unused_inputs;
  assign unused_inputs = ^{s_wb_sel, axis_i_tlast};

  assign s_wb_stall   = (state_q != StIdle);
  assign s_wb_dat_s2m = rdata_q;

  // Next-state, datapath updates and stream/bus outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    rdata_d       = rdata_q;
    we_d          = we_q;
    abort_d       = abort_q;
    axis_o_tvalid = 1'b0;
    axis_o_tlast  = 1'b0;
    axis_o_tdata  = '0;
    axis_i_tready = 1'b0;
    s_wb_ack      = 1'b0;
    data_shl      = data_q << 8;

    // Master gave up: finish the frame to keep the link aligned, but never ack
    if (state_q != StIdle && !s_wb_cyc) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (s_wb_cyc && s_wb_stb) begin
          addr_d                = '0;
          addr_d[ADDR_BITS-1:0] = s_wb_addr;
          data_d                = s_wb_dat_m2s;
          we_d                  = s_wb_we;
          abort_d               = 1'b0;
          cnt_d                 = '0;
          state_d               = StSendOp;
        end
      end
      StSendOp: begin
        axis_o_tvalid                 = 1'b1;
        axis_o_tdata[OP_WE_BIT]       = we_q;
        axis_o_tdata[OP_AUTOINC_BIT]  = 1'b0;
        if (axis_o_tready) begin
          state_d = StSendAddr;
        end
      end
      StSendAddr: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = addr_q[AW-1 -: 8];
        if (axis_o_tready) begin
          addr_d = addr_q << 8;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = StSendCount;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      StSendCount: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = 8'h01;
        axis_o_tlast  = !we_q;
        if (axis_o_tready) begin
          state_d = we_q ? StSendData : StRecvData;
        end
      end
      StSendData: begin
        axis_o_tvalid = 1'b1;
        axis_o_tdata  = data_q[DW-1 -: 8];
        axis_o_tlast  = (cnt_q == DATA_LAST);
        if (axis_o_tready) begin
          data_d = data_shl;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = StAck;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      StRecvData: begin
        axis_i_tready = 1'b1;
        if (axis_i_tvalid) begin
          data_d       = data_shl;
          data_d[7:0]  = axis_i_tdata;
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = StAck;
            // Publish the word so it is already valid in the ack cycle
            if (!abort_d) begin
              rdata_d = data_d;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      StAck: begin
        s_wb_ack = !abort_q && s_wb_cyc;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      abort_q <= abort_d;
    end
  end

endmodule
